// File: rtl/store_trace_checker_pkg.sv
// stc_pkg: shared FSM state encoding and saturating arithmetic for the store trace checker
package stc_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE, ST_HALT_ERR} stc_state_t;
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int unsigned w);
    logic [64:0] s, m;
    s = {1'b0, a} + {1'b0, b};
    m = (65'd1 << w) - 65'd1;
    return (s > m) ? m[63:0] : s[63:0];
  endfunction
endpackage

// File: rtl/store_trace_checker_if.sv
// stc_if: CPU-side, trace-load and status signals of the store trace checker
interface stc_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 32
);
  logic start, stall_d, flush_d, mem_we, exp_valid, exp_ready;
  logic cpu_en, dmem_we, mismatch, done, pass;
  logic [31:0] pc, pc_finished;
  logic [AW-1:0] mem_addr, exp_addr;
  logic [DW-1:0] mem_wdata, exp_data;
  logic [CW-1:0] cycle_cnt, instr_cnt, err_cnt;
  modport master (
    output start, pc, pc_finished, stall_d, flush_d, mem_we, mem_addr, mem_wdata, exp_valid, exp_addr, exp_data,
    input exp_ready, cpu_en, dmem_we, mismatch, done, pass, cycle_cnt, instr_cnt, err_cnt
  );
  modport slave (
    input start, pc, pc_finished, stall_d, flush_d, mem_we, mem_addr, mem_wdata, exp_valid, exp_addr, exp_data,
    output exp_ready, cpu_en, dmem_we, mismatch, done, pass, cycle_cnt, instr_cnt, err_cnt
  );
endinterface

// File: rtl/store_trace_checker_fifo.sv
// stc_fifo: expected-trace FIFO with registered count, simultaneous push/pop and sync clear
module stc_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_push,
  input  logic i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic [$clog2(DEPTH):0] o_count,
  output logic o_full,
  output logic o_empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0] r_cnt;
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wp] <= i_din;
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= i_push ? r_wp + PW'(1) : r_wp;
      r_rp <= i_pop ? r_rp + PW'(1) : r_rp;
      r_cnt <= r_cnt + (PW+1)'(i_push) - (PW+1)'(i_pop);
    end
  end
  assign o_dout = r_mem[r_rp];
  assign o_count = r_cnt;
  assign o_full = r_cnt == (PW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
endmodule

// File: rtl/store_trace_checker.sv
// store_trace_checker: in-order store trace compare, CPU clock gating and CPI counters
module store_trace_checker
  import stc_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int DEPTH = 16,
  parameter int CW = 32,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input logic clk,
  input logic reset,
  stc_if.slave s
);
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_entry_t;
  stc_state_t r_state;
  logic [31:0] r_fin_pc;
  logic [CW-1:0] r_cycle, r_instr, r_err;
  logic r_mismatch, r_done, r_pass;
  exp_entry_t w_head, w_cpu, w_exp;
  logic [$clog2(DEPTH):0] w_count;
  logic w_full, w_empty, w_push, w_pop, w_err;
  logic [CW-1:0] w_err_drain;
  assign w_cpu = {s.mem_addr, s.mem_wdata};
  assign w_exp = {s.exp_addr, s.exp_data};
  assign s.cpu_en = (r_state == ST_RUN) && (s.pc != r_fin_pc);
  assign s.dmem_we = s.mem_we & s.cpu_en;
  assign w_pop = s.dmem_we & ~w_empty;
  assign w_err = s.dmem_we & (w_empty | (w_head != w_cpu));
  // a full FIFO still takes a new entry in the cycle its head is consumed
  assign w_push = s.exp_valid & (~w_full | w_pop);
  assign w_err_drain = CW'(sat_add(64'(r_err), 64'(w_count), CW));
  stc_fifo #(.W($bits(exp_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk, .reset, .i_clr(r_state == ST_DRAIN), .i_push(w_push), .i_pop(w_pop), .i_din(w_exp),
    .o_dout(w_head), .o_count(w_count), .o_full(w_full), .o_empty(w_empty)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_fin_pc <= '0;
      r_cycle <= '0;
      r_instr <= '0;
      r_err <= '0;
      r_mismatch <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_mismatch <= w_err;
      unique case (r_state)
        ST_IDLE: if (s.start) begin
          r_state <= ST_RUN;
          r_fin_pc <= s.pc_finished;
        end
        ST_RUN: begin
          r_cycle <= CW'(sat_add(64'(r_cycle), 64'd1, CW));
          r_instr <= (s.stall_d || s.flush_d) ? r_instr : CW'(sat_add(64'(r_instr), 64'd1, CW));
          r_err <= w_err ? CW'(sat_add(64'(r_err), 64'd1, CW)) : r_err;
          if (w_err && STOP_ON_ERR) begin
            r_state <= ST_HALT_ERR;
            r_done <= 1'b1;
          end else if (s.pc == r_fin_pc) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          r_err <= w_err_drain;
          r_state <= ST_DONE;
          r_done <= 1'b1;
          r_pass <= w_err_drain == '0;
        end
        default: ;
      endcase
    end
  end
  assign s.exp_ready = ~w_full;
  assign s.mismatch = r_mismatch;
  assign s.done = r_done;
  assign s.pass = r_pass;
  assign s.cycle_cnt = r_cycle;
  assign s.instr_cnt = r_instr;
  assign s.err_cnt = r_err;
endmodule

// File: tb/tb_store_trace_checker.sv
// tb_store_trace_checker: three checker variants (stop/continue/narrow counters) against a queue-based reference model
module tb_store_trace_checker;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stall_d = 1'b0, flush_d = 1'b0, mem_we = 1'b0, exp_valid = 1'b0;
  logic [31:0] pc = '0, pc_finished = '0, mem_addr = '0, mem_wdata = '0, exp_addr = '0, exp_data = '0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  stc_if #(.AW(32), .DW(32), .CW(32)) b0 (), b1 ();
  stc_if #(.AW(32), .DW(32), .CW(4)) b2 ();
`define DRV(b) \
  assign b.start = start; assign b.pc = pc; assign b.pc_finished = pc_finished; assign b.stall_d = stall_d; \
  assign b.flush_d = flush_d; assign b.mem_we = mem_we; assign b.mem_addr = mem_addr; assign b.mem_wdata = mem_wdata; \
  assign b.exp_valid = exp_valid; assign b.exp_addr = exp_addr; assign b.exp_data = exp_data;
  `DRV(b0)
  `DRV(b1)
  `DRV(b2)
  logic d_en[3], d_we[3], d_rdy[3], d_mis[3], d_done[3], d_pass[3];
  logic [31:0] d_cyc[3], d_ins[3], d_err[3];
`define MON(b, k) \
  assign d_en[k] = b.cpu_en; assign d_we[k] = b.dmem_we; assign d_rdy[k] = b.exp_ready; assign d_mis[k] = b.mismatch; \
  assign d_done[k] = b.done; assign d_pass[k] = b.pass; assign d_cyc[k] = 32'(b.cycle_cnt); \
  assign d_ins[k] = 32'(b.instr_cnt); assign d_err[k] = 32'(b.err_cnt);
  `MON(b0, 0)
  `MON(b1, 1)
  `MON(b2, 2)
  store_trace_checker #(.STOP_ON_ERR(1'b0)) u0 (.clk(clk), .reset(reset), .s(b0));
  store_trace_checker #(.STOP_ON_ERR(1'b1)) u1 (.clk(clk), .reset(reset), .s(b1));
  store_trace_checker #(.CW(4), .STOP_ON_ERR(1'b0)) u2 (.clk(clk), .reset(reset), .s(b2));

  // reference model: phase per variant, expected trace as a queue, counters as plain clamped integers
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3, M_HALT = 4;
  bit m_stop[3] = '{1'b0, 1'b1, 1'b0};
  longint m_max[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 15};
  logic [63:0] mq[3][$];
  int m_st[3] = '{0, 0, 0};
  logic [31:0] m_fpc[3] = '{0, 0, 0};
  longint m_cyc[3] = '{0, 0, 0}, m_ins[3] = '{0, 0, 0}, m_err[3] = '{0, 0, 0};
  bit m_done[3], m_pass[3], m_mis[3];
  bit me_en, me_we, me_pop, me_er;
  int me_occ;
  function automatic longint clamp(longint v, int k);
    return v > m_max[k] ? m_max[k] : v;
  endfunction
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        mq[k].delete();
        m_st[k] = M_IDLE; m_fpc[k] = '0; m_cyc[k] = 0; m_ins[k] = 0; m_err[k] = 0;
        m_done[k] = 0; m_pass[k] = 0; m_mis[k] = 0;
      end else begin
        me_occ = mq[k].size();
        me_en = m_st[k] == M_RUN && pc != m_fpc[k];
        me_we = mem_we && me_en;
        me_pop = me_we && me_occ > 0;
        me_er = me_we && ((me_occ == 0) ? 1'b1 : (mq[k][0] != {mem_addr, mem_wdata}));
        m_mis[k] = me_er;
        if (me_pop) void'(mq[k].pop_front());
        if (exp_valid && (me_occ < 16 || me_pop)) mq[k].push_back({exp_addr, exp_data});
        if (m_st[k] == M_IDLE && start) begin
          m_st[k] = M_RUN; m_fpc[k] = pc_finished;
        end else if (m_st[k] == M_RUN) begin
          m_cyc[k] = clamp(m_cyc[k] + 1, k);
          if (!stall_d && !flush_d) m_ins[k] = clamp(m_ins[k] + 1, k);
          if (me_er) m_err[k] = clamp(m_err[k] + 1, k);
          if (me_er && m_stop[k]) begin m_st[k] = M_HALT; m_done[k] = 1; end
          else if (pc == m_fpc[k]) m_st[k] = M_DRAIN;
        end else if (m_st[k] == M_DRAIN) begin
          m_err[k] = clamp(m_err[k] + me_occ, k);
          mq[k].delete();
          m_st[k] = M_DONE; m_done[k] = 1; m_pass[k] = m_err[k] == 0;
        end
      end
    end
  end
  // tally combinational-output disagreements and mismatch pulses for the scenario tasks to judge
  int cmb_bad[3] = '{0, 0, 0}, dm[3] = '{0, 0, 0}, mm[3] = '{0, 0, 0};
  bit mon_en;
  always @(negedge clk) begin
    #2;
    for (int k = 0; k < 3; k++) begin
      mon_en = m_st[k] == M_RUN && pc != m_fpc[k];
      if (d_en[k] !== mon_en || d_we[k] !== (mem_we && mon_en) || d_rdy[k] !== (mq[k].size() < 16)) cmb_bad[k]++;
      dm[k] += int'(d_mis[k] === 1'b1);
      mm[k] += int'(m_mis[k]);
    end
  end

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset;
    reset = 1; start = 0; mem_we = 0; exp_valid = 0; stall_d = 0; flush_d = 0; pc = '0;
    step;
    reset = 0;
  endtask
  task automatic load(input logic [31:0] a, input logic [31:0] d);
    exp_valid = 1; exp_addr = a; exp_data = d;
    step;
    exp_valid = 0;
  endtask
  bit c_we[64], c_st[64], c_fl[64], c_ev[64];
  logic [31:0] c_a[64], c_d[64], c_ea[64], c_ed[64];
  logic [31:0] ea[32], ed[32];
  task automatic clear_prog(input bit rnd_sf);
    for (int i = 0; i < 64; i++) begin
      c_we[i] = 0; c_ev[i] = 0; c_a[i] = $urandom; c_d[i] = $urandom; c_ea[i] = $urandom; c_ed[i] = $urandom;
      c_st[i] = rnd_sf && $urandom_range(0, 3) == 0;
      c_fl[i] = rnd_sf && !c_st[i] && $urandom_range(0, 5) == 0;
    end
  endtask
  task automatic run_cpu(input int n);
    start = 1; pc = '0; pc_finished = 32'(4 * n); mem_we = 1; mem_addr = $urandom; mem_wdata = $urandom;
    step;
    start = 0;
    for (int i = 0; i <= n; i++) begin
      pc = 32'(4 * i); mem_we = c_we[i]; mem_addr = c_a[i]; mem_wdata = c_d[i]; stall_d = c_st[i]; flush_d = c_fl[i];
      exp_valid = c_ev[i]; exp_addr = c_ea[i]; exp_data = c_ed[i];
      step;
    end
    mem_we = 1; exp_valid = 0; stall_d = 0; flush_d = 0;
    step;
    mem_we = 0;
    step;
    step;
  endtask

  task automatic test_reset;
    do_reset;
    for (int k = 0; k < 3; k++) begin
      checks += 8;
      if (d_done[k] !== 1'b0) begin failures++; $display("FAIL reset_done k=%0d got=%b exp=0", k, d_done[k]); end
      if (d_pass[k] !== 1'b0) begin failures++; $display("FAIL reset_pass k=%0d got=%b exp=0", k, d_pass[k]); end
      if (d_mis[k] !== 1'b0) begin failures++; $display("FAIL reset_mismatch k=%0d got=%b exp=0", k, d_mis[k]); end
      if (d_en[k] !== 1'b0) begin failures++; $display("FAIL reset_cpu_en k=%0d got=%b exp=0", k, d_en[k]); end
      if (d_rdy[k] !== 1'b1) begin failures++; $display("FAIL reset_exp_ready k=%0d got=%b exp=1", k, d_rdy[k]); end
      if (d_cyc[k] !== 0) begin failures++; $display("FAIL reset_cycle k=%0d got=%0d exp=0", k, d_cyc[k]); end
      if (d_ins[k] !== 0) begin failures++; $display("FAIL reset_instr k=%0d got=%0d exp=0", k, d_ins[k]); end
      if (d_err[k] !== 0) begin failures++; $display("FAIL reset_err k=%0d got=%0d exp=0", k, d_err[k]); end
    end
  endtask

  task automatic test_pass;
    int ne;
    do_reset;
    clear_prog(1);
    ne = $urandom_range(2, 5);
    ea[0] = 32'h4; ed[0] = 32'h5; ea[1] = 32'h8; ed[1] = 32'h7;
    for (int j = 2; j < ne; j++) begin ea[j] = {$urandom_range(0, 255), 2'b00}; ed[j] = $urandom; end
    for (int j = 0; j < ne; j++) begin
      load(ea[j], ed[j]);
      c_we[2 * j + 1] = 1; c_a[2 * j + 1] = ea[j]; c_d[2 * j + 1] = ed[j];
    end
    c_we[16] = 1;
    run_cpu(16);
    for (int k = 0; k < 3; k++) begin
      checks += 8;
      if (d_done[k] !== 1'b1) begin failures++; $display("FAIL pass_done k=%0d got=%b exp=1", k, d_done[k]); end
      if (d_pass[k] !== 1'b1) begin failures++; $display("FAIL pass_pass k=%0d got=%b exp=1", k, d_pass[k]); end
      if (d_err[k] !== 0) begin failures++; $display("FAIL pass_err k=%0d got=%0d exp=0", k, d_err[k]); end
      if (d_cyc[k] !== 32'(m_cyc[k])) begin failures++; $display("FAIL pass_cycle k=%0d got=%0d exp=%0d", k, d_cyc[k], m_cyc[k]); end
      if (d_ins[k] !== 32'(m_ins[k])) begin failures++; $display("FAIL pass_instr k=%0d got=%0d exp=%0d", k, d_ins[k], m_ins[k]); end
      if (d_cyc[k] !== (k == 2 ? 32'd15 : 32'd17)) begin failures++; $display("FAIL pass_cycle_abs k=%0d got=%0d", k, d_cyc[k]); end
      if (dm[k] !== mm[k]) begin failures++; $display("FAIL pass_mismatch_pulses k=%0d got=%0d exp=%0d", k, dm[k], mm[k]); end
      if (cmb_bad[k] !== 0) begin failures++; $display("FAIL pass_comb_outputs k=%0d got=%0d bad cycles exp=0", k, cmb_bad[k]); end
    end
  endtask

  task automatic test_mismatch_halt;
    int dm1;
    do_reset;
    clear_prog(1);
    load(32'h4, 32'h5);
    load({$urandom_range(0, 255), 2'b00}, $urandom);
    c_we[1] = 1; c_a[1] = 32'h4; c_d[1] = 32'h6;
    dm1 = dm[1];
    run_cpu(8);
    pc = '0;
    #1;
    checks += 5;
    if (d_done[1] !== 1'b1) begin failures++; $display("FAIL halt_done got=%b exp=1", d_done[1]); end
    if (d_pass[1] !== 1'b0) begin failures++; $display("FAIL halt_pass got=%b exp=0", d_pass[1]); end
    if (d_err[1] !== 1) begin failures++; $display("FAIL halt_err got=%0d exp=1", d_err[1]); end
    if (d_en[1] !== 1'b0) begin failures++; $display("FAIL halt_cpu_en got=%b exp=0", d_en[1]); end
    if (dm[1] - dm1 !== 1) begin failures++; $display("FAIL halt_mismatch_pulses got=%0d exp=1", dm[1] - dm1); end
    for (int k = 0; k < 3; k++) begin
      checks += 4;
      if (d_err[k] !== 32'(m_err[k])) begin failures++; $display("FAIL halt_model_err k=%0d got=%0d exp=%0d", k, d_err[k], m_err[k]); end
      if (d_pass[k] !== m_pass[k]) begin failures++; $display("FAIL halt_model_pass k=%0d got=%b exp=%b", k, d_pass[k], m_pass[k]); end
      if (d_cyc[k] !== 32'(m_cyc[k])) begin failures++; $display("FAIL halt_model_cycle k=%0d got=%0d exp=%0d", k, d_cyc[k], m_cyc[k]); end
      if (dm[k] !== mm[k]) begin failures++; $display("FAIL halt_model_pulses k=%0d got=%0d exp=%0d", k, dm[k], mm[k]); end
    end
  endtask

  task automatic test_errors_continue;
    logic [31:0] a, d;
    do_reset;
    clear_prog(1);
    a = {$urandom_range(0, 255), 2'b00}; d = $urandom;
    load(a, d);
    c_we[1] = 1; c_a[1] = a; c_d[1] = d ^ (32'd1 << $urandom_range(0, 31));
    c_we[3] = 1;
    c_ev[5] = 1; c_ev[6] = 1;
    run_cpu(10);
    checks += 5;
    if (d_err[0] !== 4) begin failures++; $display("FAIL cont_err got=%0d exp=4", d_err[0]); end
    if (d_pass[0] !== 1'b0) begin failures++; $display("FAIL cont_pass got=%b exp=0", d_pass[0]); end
    if (d_done[0] !== 1'b1) begin failures++; $display("FAIL cont_done got=%b exp=1", d_done[0]); end
    if (d_err[1] !== 1) begin failures++; $display("FAIL cont_stop_err got=%0d exp=1", d_err[1]); end
    if (d_err[2] !== 4) begin failures++; $display("FAIL cont_narrow_err got=%0d exp=4", d_err[2]); end
    for (int k = 0; k < 3; k++) begin
      checks += 3;
      if (d_err[k] !== 32'(m_err[k])) begin failures++; $display("FAIL cont_model_err k=%0d got=%0d exp=%0d", k, d_err[k], m_err[k]); end
      if (dm[k] !== mm[k]) begin failures++; $display("FAIL cont_model_pulses k=%0d got=%0d exp=%0d", k, dm[k], mm[k]); end
      if (cmb_bad[k] !== 0) begin failures++; $display("FAIL cont_comb_outputs k=%0d got=%0d exp=0", k, cmb_bad[k]); end
    end
  endtask

  task automatic test_fifo_full;
    do_reset;
    clear_prog(1);
    for (int j = 0; j < 17; j++) begin ea[j] = $urandom; ed[j] = $urandom; end
    for (int j = 0; j < 16; j++) load(ea[j], ed[j]);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d_rdy[k] !== 1'b0) begin failures++; $display("FAIL full_ready k=%0d got=%b exp=0", k, d_rdy[k]); end
    end
    c_ev[0] = 1; c_ea[0] = ea[16]; c_ed[0] = ed[16];
    for (int j = 0; j < 17; j++) begin c_we[j] = 1; c_a[j] = ea[j]; c_d[j] = ed[j]; end
    run_cpu(18);
    for (int k = 0; k < 3; k++) begin
      checks += 4;
      if (d_pass[k] !== 1'b1) begin failures++; $display("FAIL full_pass k=%0d got=%b exp=1", k, d_pass[k]); end
      if (d_err[k] !== 0) begin failures++; $display("FAIL full_err k=%0d got=%0d exp=0", k, d_err[k]); end
      if (d_rdy[k] !== 1'b1) begin failures++; $display("FAIL full_ready_after k=%0d got=%b exp=1", k, d_rdy[k]); end
      if (cmb_bad[k] !== 0) begin failures++; $display("FAIL full_comb_outputs k=%0d got=%0d exp=0", k, cmb_bad[k]); end
    end
  endtask

  task automatic test_counters;
    int p0, p1, p2;
    do_reset;
    clear_prog(0);
    p0 = $urandom_range(0, 9);
    do p1 = $urandom_range(0, 9); while (p1 == p0);
    do p2 = $urandom_range(0, 9); while (p2 == p0 || p2 == p1);
    c_st[p0] = 1; c_st[p1] = 1; c_fl[p2] = 1;
    run_cpu(9);
    for (int k = 0; k < 3; k++) begin
      checks += 3;
      if (d_cyc[k] !== 10) begin failures++; $display("FAIL cnt_cycle k=%0d got=%0d exp=10", k, d_cyc[k]); end
      if (d_ins[k] !== 7) begin failures++; $display("FAIL cnt_instr k=%0d got=%0d exp=7", k, d_ins[k]); end
      if (d_pass[k] !== 1'b1) begin failures++; $display("FAIL cnt_pass k=%0d got=%b exp=1", k, d_pass[k]); end
    end
  endtask

  task automatic test_reset_mid_run;
    do_reset;
    for (int j = 0; j < 3; j++) load($urandom, $urandom);
    start = 1; pc = '0; pc_finished = 32'h100;
    step;
    start = 0;
    for (int i = 1; i < 5; i++) begin pc = 32'(4 * i); stall_d = $urandom_range(0, 1); step; end
    reset = 1; stall_d = 0;
    step;
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      checks += 5;
      if (d_en[k] !== 1'b0) begin failures++; $display("FAIL mid_cpu_en k=%0d got=%b exp=0", k, d_en[k]); end
      if (d_rdy[k] !== 1'b1) begin failures++; $display("FAIL mid_exp_ready k=%0d got=%b exp=1", k, d_rdy[k]); end
      if (d_cyc[k] !== 0) begin failures++; $display("FAIL mid_cycle k=%0d got=%0d exp=0", k, d_cyc[k]); end
      if (d_ins[k] !== 0) begin failures++; $display("FAIL mid_instr k=%0d got=%0d exp=0", k, d_ins[k]); end
      if (d_done[k] !== 1'b0) begin failures++; $display("FAIL mid_done k=%0d got=%b exp=0", k, d_done[k]); end
    end
    clear_prog(1);
    run_cpu(4);
    for (int k = 0; k < 3; k++) begin
      checks += 2;
      if (d_err[k] !== 0) begin failures++; $display("FAIL mid_rerun_err k=%0d got=%0d exp=0", k, d_err[k]); end
      if (d_pass[k] !== 1'b1) begin failures++; $display("FAIL mid_rerun_pass k=%0d got=%b exp=1", k, d_pass[k]); end
    end
  endtask

  task automatic test_random;
    int ne, n, j;
    for (int it = 0; it < 6; it++) begin
      do_reset;
      clear_prog(1);
      ne = $urandom_range(0, 8);
      n = $urandom_range(ne + 2, 30);
      for (int e = 0; e < ne; e++) begin ea[e] = $urandom; ed[e] = $urandom; load(ea[e], ed[e]); end
      j = 0;
      for (int i = 0; i < n; i++) begin
        c_we[i] = $urandom_range(0, 2) == 0;
        c_ev[i] = $urandom_range(0, 9) == 0;
        if (c_we[i] && j < ne) begin
          c_a[i] = ea[j];
          c_d[i] = ($urandom_range(0, 5) == 0) ? ed[j] ^ 32'h80 : ed[j];
          j++;
        end
      end
      run_cpu(n);
      for (int k = 0; k < 3; k++) begin
        checks += 6;
        if (d_done[k] !== m_done[k]) begin failures++; $display("FAIL rnd_done it=%0d k=%0d got=%b exp=%b", it, k, d_done[k], m_done[k]); end
        if (d_pass[k] !== m_pass[k]) begin failures++; $display("FAIL rnd_pass it=%0d k=%0d got=%b exp=%b", it, k, d_pass[k], m_pass[k]); end
        if (d_err[k] !== 32'(m_err[k])) begin failures++; $display("FAIL rnd_err it=%0d k=%0d got=%0d exp=%0d", it, k, d_err[k], m_err[k]); end
        if (d_cyc[k] !== 32'(m_cyc[k])) begin failures++; $display("FAIL rnd_cycle it=%0d k=%0d got=%0d exp=%0d", it, k, d_cyc[k], m_cyc[k]); end
        if (d_ins[k] !== 32'(m_ins[k])) begin failures++; $display("FAIL rnd_instr it=%0d k=%0d got=%0d exp=%0d", it, k, d_ins[k], m_ins[k]); end
        if (dm[k] !== mm[k]) begin failures++; $display("FAIL rnd_pulses it=%0d k=%0d got=%0d exp=%0d", it, k, dm[k], mm[k]); end
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (cmb_bad[k] !== 0) begin failures++; $display("FAIL rnd_comb_outputs k=%0d got=%0d exp=0", k, cmb_bad[k]); end
    end
  endtask

  initial begin
    test_reset;
    test_pass;
    test_mismatch_halt;
    test_errors_continue;
    test_fifo_full;
    test_counters;
    test_reset_mid_run;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
